// File: rtl/clk_div_pkg.sv
// Shared constants for the clock divider bank: output mode encoding and
// the divide value every channel comes out of reset with.
package clk_div_pkg;

  localparam logic MODE_TOGGLE = 1'b0;
  localparam logic MODE_PULSE  = 1'b1;

  // 100 MHz / (2 * (4999 + 1)) = 10 kHz toggle output
  localparam int DEF_RST_DIV = 4999;

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: wrap counter, shadow/active config pair and
// registered tick / divided outputs.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int RST_DIV = DEF_RST_DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_sel,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic             cfg_mode,
  output logic             div_out,
  output logic             tick,
  output logic             cfg_pend
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] act_div;
  logic [CNT_W-1:0] sh_div;
  logic             act_mode;
  logic             sh_mode;
  logic             pend;
  logic             wrap;

  assign wrap     = en && (cnt == act_div);
  assign cfg_pend = pend;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      act_div  <= CNT_W'(RST_DIV);
      sh_div   <= CNT_W'(RST_DIV);
      act_mode <= MODE_TOGGLE;
      sh_mode  <= MODE_TOGGLE;
      pend     <= 1'b0;
      div_out  <= 1'b0;
      tick     <= 1'b0;
    end else begin
      if (cfg_sel) begin
        sh_div  <= cfg_div;
        sh_mode <= cfg_mode;
      end
      if (!en) begin
        // Idle channel: no period to protect, so a pending config lands at once
        cnt     <= '0;
        div_out <= 1'b0;
        tick    <= 1'b0;
        if (cfg_sel) begin
          pend <= 1'b1;
        end else if (pend) begin
          act_div  <= sh_div;
          act_mode <= sh_mode;
          pend     <= 1'b0;
        end
      end else if (wrap) begin
        // The closing period's mode decides this edge; new config starts after it
        cnt     <= '0;
        tick    <= 1'b1;
        div_out <= (act_mode == MODE_PULSE) ? 1'b1 : ~div_out;
        pend    <= 1'b0;
        if (cfg_sel) begin
          act_div  <= cfg_div;
          act_mode <= cfg_mode;
        end else if (pend) begin
          act_div  <= sh_div;
          act_mode <= sh_mode;
        end
      end else begin
        cnt  <= cnt + CNT_W'(1);
        tick <= 1'b0;
        if (act_mode == MODE_PULSE) begin
          div_out <= 1'b0;
        end
        if (cfg_sel) begin
          pend <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/clk_div_bank.sv
// Bank of independent clock dividers sharing one config write port;
// decodes the target channel and instantiates one clk_div_chan per channel.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int  NUM_CH  = 4,
  parameter int  CNT_W   = 16,
  parameter int  RST_DIV = DEF_RST_DIV,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic              cfg_mode,
  output logic [NUM_CH-1:0] div_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] cfg_pend
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic sel;

    // Addresses past the last channel match nothing and are dropped
    assign sel = cfg_we && (cfg_ch == CH_W'(i));

    clk_div_chan #(
      .CNT_W  (CNT_W),
      .RST_DIV(RST_DIV)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .en      (ch_en[i]),
      .cfg_sel (sel),
      .cfg_div (cfg_div),
      .cfg_mode(cfg_mode),
      .div_out (div_out[i]),
      .tick    (tick[i]),
      .cfg_pend(cfg_pend[i])
    );
  end

endmodule
